bp_fe_mem_arbiter: RTL and testbench

BP_FE_MEM_ARBITER -- requirements
Module: bp_fe_mem_arbiter

---
 rtl/bp_fe_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_bp_fe_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_mem_arbiter.sv
// Front-end memory arbiter: merges unbuffered fetches with a 2-deep ctrl (TLB fill/fence) queue,
// throttles issue around fences and tracks the two-cycle response pipeline.
module bp_fe_mem_arbiter #(
    parameter int mem_cmd_width_p = 64,
    parameter int starve_limit_p  = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [mem_cmd_width_p-1:0] fetch_cmd_i,
    input  logic                       fetch_v_i,
    output logic                       fetch_yumi_o,
    input  logic [mem_cmd_width_p-1:0] ctrl_cmd_i,
    input  logic                       ctrl_v_i,
    output logic                       ctrl_ready_o,
    output logic [mem_cmd_width_p-1:0] mem_cmd_o,
    output logic                       mem_cmd_v_o,
    input  logic                       mem_cmd_yumi_i,
    input  logic                       mem_resp_v_i,
    input  logic                       flush_i,
    output logic                       fetch_resp_v_o,
    output logic                       ctrl_done_o
);

    localparam int starve_w_lp = $clog2(starve_limit_p + 1);
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

    // The op field occupies the two LSBs of a bp_fe_mem_cmd_s.
    localparam logic [1:0] e_fe_op_fetch     = 2'd0;
    localparam logic [1:0] e_fe_op_tlb_fill  = 2'd1;
    localparam logic [1:0] e_fe_op_tlb_fence = 2'd2;

    typedef enum logic {
        e_ready = 1'b0,
        e_drain = 1'b1
    } state_e;

    state_e                     r_state;
    logic [mem_cmd_width_p-1:0] r_fifo_mem [2];
    logic                       r_fifo_wptr;
    logic                       r_fifo_rptr;
    logic [1:0]                 r_fifo_cnt;
    logic [starve_w_lp-1:0]     r_starve;
    logic                       r_s0_v;
    logic                       r_s0_ctrl;
    logic                       r_s1_v;
    logic                       r_s1_ctrl;

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_state_ready;
    logic w_fetch_prio;
    logic w_grant_ctrl;
    logic w_grant_fetch;
    logic w_cmd_v;
    logic w_accept;
    logic w_enq;
    logic w_deq;
    logic w_fetch_acc;
    logic w_fence_acc;
    logic w_s0_v_next;
    logic w_s1_v_next;

    assign w_fifo_full   = (r_fifo_cnt == 2'd2);
    assign w_fifo_empty  = (r_fifo_cnt == 2'd0);
    assign w_state_ready = (r_state == e_ready);

    // Fetch overrides the ctrl queue only once it has been passed over starve_limit_p times.
    assign w_fetch_prio  = fetch_v_i & (r_starve == starve_max_lp);
    assign w_grant_ctrl  = w_state_ready & ~w_fifo_empty & ~w_fetch_prio;
    assign w_grant_fetch = w_state_ready & fetch_v_i & ~w_grant_ctrl;
    assign w_cmd_v       = w_state_ready & (~w_fifo_empty | fetch_v_i);

    assign w_accept    = mem_cmd_yumi_i & w_cmd_v;
    assign w_enq       = ctrl_v_i & ~w_fifo_full;
    assign w_deq       = mem_cmd_yumi_i & w_grant_ctrl;
    assign w_fetch_acc = mem_cmd_yumi_i & w_grant_fetch;
    assign w_fence_acc = w_accept & (mem_cmd_o[1:0] == e_fe_op_tlb_fence);

    // Flush kills fetch entries only; ctrl entries always retire.
    assign w_s0_v_next = w_accept & ~(flush_i & ~w_grant_ctrl);
    assign w_s1_v_next = r_s0_v & ~(flush_i & ~r_s0_ctrl);

    assign mem_cmd_o      = w_grant_ctrl ? r_fifo_mem[r_fifo_rptr] : fetch_cmd_i;
    assign mem_cmd_v_o    = w_cmd_v & ~reset_i;
    assign fetch_yumi_o   = w_fetch_acc & ~reset_i;
    assign ctrl_ready_o   = ~w_fifo_full | reset_i;
    assign fetch_resp_v_o = mem_resp_v_i & r_s1_v & ~r_s1_ctrl & ~reset_i;
    assign ctrl_done_o    = r_s1_v & r_s1_ctrl & ~reset_i;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo_mem[r_fifo_wptr] <= ctrl_cmd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fifo_wptr <= 1'b0;
            r_fifo_rptr <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (w_enq) begin
                r_fifo_wptr <= ~r_fifo_wptr;
            end
            if (w_deq) begin
                r_fifo_rptr <= ~r_fifo_rptr;
            end
            case ({w_enq, w_deq})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_starve <= '0;
        end else if (!fetch_v_i || w_fetch_acc) begin
            r_starve <= '0;
        end else if (w_deq && (r_starve != starve_max_lp)) begin
            r_starve <= r_starve + starve_w_lp'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // Drain exits as soon as stage 0 is empty: stage 1 retires this cycle, so both are clear next.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= e_ready;
            r_s0_v    <= 1'b0;
            r_s0_ctrl <= 1'b0;
            r_s1_v    <= 1'b0;
            r_s1_ctrl <= 1'b0;
        end else begin
            r_s0_v    <= w_s0_v_next;
            r_s0_ctrl <= w_grant_ctrl;
            r_s1_v    <= w_s1_v_next;
            r_s1_ctrl <= r_s0_ctrl;
            case (r_state)
                e_ready: r_state <= w_fence_acc ? e_drain : e_ready;
                e_drain: r_state <= r_s0_v ? e_drain : e_ready;
                default: r_state <= e_ready;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_fe_mem_arbiter.sv
// Self-checking bench for bp_fe_mem_arbiter: a cycle table for fetch/fence/flush paths,
// a scoreboard queue for the starvation grant order, and hand-written reset/full-FIFO sequences.
module tb_bp_fe_mem_arbiter;

    localparam int W = 64;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] fetch_cmd_i;
    logic         fetch_v_i;
    logic         fetch_yumi_o;
    logic [W-1:0] ctrl_cmd_i;
    logic         ctrl_v_i;
    logic         ctrl_ready_o;
    logic [W-1:0] mem_cmd_o;
    logic         mem_cmd_v_o;
    logic         mem_cmd_yumi_i;
    logic         mem_resp_v_i;
    logic         flush_i;
    logic         fetch_resp_v_o;
    logic         ctrl_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_fe_mem_arbiter #(.mem_cmd_width_p(W), .starve_limit_p(4)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fetch_cmd_i    (fetch_cmd_i),
        .fetch_v_i      (fetch_v_i),
        .fetch_yumi_o   (fetch_yumi_o),
        .ctrl_cmd_i     (ctrl_cmd_i),
        .ctrl_v_i       (ctrl_v_i),
        .ctrl_ready_o   (ctrl_ready_o),
        .mem_cmd_o      (mem_cmd_o),
        .mem_cmd_v_o    (mem_cmd_v_o),
        .mem_cmd_yumi_i (mem_cmd_yumi_i),
        .mem_resp_v_i   (mem_resp_v_i),
        .flush_i        (flush_i),
        .fetch_resp_v_o (fetch_resp_v_o),
        .ctrl_done_o    (ctrl_done_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [1:0] OP_FETCH = 2'd0;
    localparam logic [1:0] OP_FILL  = 2'd1;
    localparam logic [1:0] OP_FENCE = 2'd2;

    function automatic logic [W-1:0] mk(input logic [7:0] tag, input logic [1:0] op);
        return {54'd0, tag, op};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic       fetch_v;
        logic       ctrl_v;
        logic [1:0] ctrl_op;
        logic       yumi;
        logic       resp;
        logic       flush;
        logic       e_mem_v;
        logic       e_fyumi;
        logic       e_ready;
        logic       e_fresp;
        logic       e_done;
    } vec_t;

    vec_t vecs [19];

    logic [W-1:0] fcmd;
    logic [W-1:0] sb [$];
    logic [W-1:0] exp_cmd;
    logic [W-1:0] scmd [6];
    int           sidx;
    int           cyc;

    initial begin
        fcmd = mk(8'hFE, OP_FETCH);
        for (int i = 0; i < 6; i++) begin
            scmd[i] = mk(8'(8'h10 + i), OP_FILL);
        end
        //           fv    cv    op        yumi  resp  flush  mem_v fyumi ready fresp done
        vecs[0]  = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, OP_FENCE, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, OP_FILL,  1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, OP_FILL,  1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, OP_FILL,  1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, OP_FILL,  1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, OP_FILL,  1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, OP_FILL,  1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, OP_FILL,  1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, OP_FILL,  1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, OP_FILL,  1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset with every request asserted: all outputs must stay quiet.
        reset_i = 1'b1; fetch_cmd_i = fcmd; fetch_v_i = 1'b1; ctrl_cmd_i = mk(8'h01, OP_FILL);
        ctrl_v_i = 1'b1; mem_cmd_yumi_i = 1'b1; mem_resp_v_i = 1'b1; flush_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        chk("rst_mem_v", W'(mem_cmd_v_o), W'(1'b0));
        chk("rst_fyumi", W'(fetch_yumi_o), W'(1'b0));
        chk("rst_ready", W'(ctrl_ready_o), W'(1'b1));
        chk("rst_fresp", W'(fetch_resp_v_o), W'(1'b0));
        chk("rst_done", W'(ctrl_done_o), W'(1'b0));
        next_cycle();
        reset_i = 1'b0; fetch_v_i = 1'b0; ctrl_v_i = 1'b0; mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0;
        @(negedge clk_i);
        chk("idle_mem_v", W'(mem_cmd_v_o), W'(1'b0));
        chk("idle_ready", W'(ctrl_ready_o), W'(1'b1));
        chk("idle_done", W'(ctrl_done_o), W'(1'b0));
        next_cycle();

        for (int i = 0; i < 19; i++) begin
            fetch_v_i      = vecs[i].fetch_v;
            ctrl_v_i       = vecs[i].ctrl_v;
            ctrl_cmd_i     = mk(8'(i), vecs[i].ctrl_op);
            mem_cmd_yumi_i = vecs[i].yumi;
            mem_resp_v_i   = vecs[i].resp;
            flush_i        = vecs[i].flush;
            @(negedge clk_i);
            chk($sformatf("row%0d_mem_v", i), W'(mem_cmd_v_o), W'(vecs[i].e_mem_v));
            chk($sformatf("row%0d_fyumi", i), W'(fetch_yumi_o), W'(vecs[i].e_fyumi));
            chk($sformatf("row%0d_ready", i), W'(ctrl_ready_o), W'(vecs[i].e_ready));
            chk($sformatf("row%0d_fresp", i), W'(fetch_resp_v_o), W'(vecs[i].e_fresp));
            chk($sformatf("row%0d_done", i), W'(ctrl_done_o), W'(vecs[i].e_done));
            next_cycle();
        end
        fetch_v_i = 1'b0; ctrl_v_i = 1'b0; mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0; flush_i = 1'b0;
        next_cycle();

        // Full FIFO: ready drops after two enqueues, head stays put, one dequeue reopens it.
        ctrl_v_i = 1'b1; ctrl_cmd_i = mk(8'hA0, OP_FILL);
        @(negedge clk_i);
        chk("full_c0_ready", W'(ctrl_ready_o), W'(1'b1));
        next_cycle();
        ctrl_cmd_i = mk(8'hB0, OP_FILL);
        @(negedge clk_i);
        chk("full_c1_ready", W'(ctrl_ready_o), W'(1'b1));
        chk("full_c1_cmd", mem_cmd_o, mk(8'hA0, OP_FILL));
        next_cycle();
        ctrl_cmd_i = mk(8'hC0, OP_FILL);
        @(negedge clk_i);
        chk("full_c2_ready", W'(ctrl_ready_o), W'(1'b0));
        chk("full_c2_cmd", mem_cmd_o, mk(8'hA0, OP_FILL));
        next_cycle();
        mem_cmd_yumi_i = 1'b1;
        @(negedge clk_i);
        chk("full_c3_ready", W'(ctrl_ready_o), W'(1'b0));
        chk("full_c3_cmd", mem_cmd_o, mk(8'hA0, OP_FILL));
        next_cycle();
        ctrl_v_i = 1'b0; mem_cmd_yumi_i = 1'b0;
        @(negedge clk_i);
        chk("full_c4_ready", W'(ctrl_ready_o), W'(1'b1));
        chk("full_c4_cmd", mem_cmd_o, mk(8'hB0, OP_FILL));
        next_cycle();
        mem_cmd_yumi_i = 1'b1;
        next_cycle();
        mem_cmd_yumi_i = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();

        // Starvation: prefill two ctrl, then fetch waits behind exactly four ctrl grants.
        for (int i = 0; i < 4; i++) sb.push_back(scmd[i]);
        sb.push_back(fcmd);
        sb.push_back(scmd[4]);
        sb.push_back(scmd[5]);
        sidx = 0;
        cyc  = 0;
        while (sb.size() > 0 && cyc < 40) begin
            fetch_v_i      = (sidx >= 2);
            mem_cmd_yumi_i = (sidx >= 2);
            ctrl_v_i       = (sidx < 6);
            ctrl_cmd_i     = scmd[(sidx < 6) ? sidx : 5];
            @(negedge clk_i);
            if (mem_cmd_v_o && mem_cmd_yumi_i) begin
                exp_cmd = sb.pop_front();
                chk($sformatf("starve_order%0d", 7 - sb.size() - 1), mem_cmd_o, exp_cmd);
                chk($sformatf("starve_fyumi%0d", 7 - sb.size() - 1), W'(fetch_yumi_o),
                    W'(exp_cmd == fcmd));
            end
            if (ctrl_v_i && ctrl_ready_o) sidx++;
            next_cycle();
            cyc++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL starve_timeout: %0d grants still expected, expected 0", sb.size());
        end
        fetch_v_i = 1'b0; ctrl_v_i = 1'b0; mem_cmd_yumi_i = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();

        // Reset in the middle of a drain with one ctrl entry left queued.
        ctrl_v_i = 1'b1; ctrl_cmd_i = mk(8'hD0, OP_FENCE);
        next_cycle();
        ctrl_cmd_i = mk(8'hD1, OP_FILL); mem_cmd_yumi_i = 1'b1;
        @(negedge clk_i);
        chk("rd_fence_issue", mem_cmd_o, mk(8'hD0, OP_FENCE));
        next_cycle();
        ctrl_v_i = 1'b0; mem_cmd_yumi_i = 1'b0; fetch_v_i = 1'b1;
        @(negedge clk_i);
        chk("rd_drain_block", W'(mem_cmd_v_o), W'(1'b0));
        next_cycle();
        reset_i = 1'b1;
        next_cycle();
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rd_post_mem_v", W'(mem_cmd_v_o), W'(1'b1));
        chk("rd_post_cmd", mem_cmd_o, fcmd);
        chk("rd_post_ready", W'(ctrl_ready_o), W'(1'b1));
        next_cycle();
        fetch_v_i = 1'b0;
        @(negedge clk_i);
        chk("rd_empty_mem_v", W'(mem_cmd_v_o), W'(1'b0));
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
